scan_test_ctrl: RTL and testbench
=================================

SCAN_TEST_CTRL -- requirements
Module: scan_test_ctrl

Interface
REQ-001 Parameter: CHAIN_LEN, default 4, number of flip-flops in the driven scan chain (legal range 2..16).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to run one scan test; honoured only in IDLE.
REQ-005 pattern_in  input  CHAIN_LEN  value to load into the chain; bit k targets chain FF k.
REQ-006 expect_in  input  CHAIN_LEN  expected chain contents after capture.
REQ-007 chain_so  input  1  scan output of the last chain FF.
REQ-008 scan_en  output  1  chain shift enable, registered.
REQ-009 scan_in  output  1  serial data into chain FF 0, registered.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse when the result is valid.
REQ-012 pass  output  1  1 when captured == expected; held until next accepted start.
REQ-013 captured  output  CHAIN_LEN  unloaded chain contents; bit k = FF k; held until next accepted start.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, CAPTURE, UNLOAD, COMPARE.
REQ-015 In IDLE with start=1, pattern_in and expect_in SHALL be latched and the FSM SHALL enter LOAD at the same edge; captured SHALL clear to 0 and pass to 0.
REQ-016 LOAD SHALL last exactly CHAIN_LEN cycles with scan_en=1; in LOAD cycle i (i=0..CHAIN_LEN-1), scan_in = latched pattern bit CHAIN_LEN-1-i, so FF k holds pattern bit k after the last shift.
REQ-017 CAPTURE SHALL last exactly 1 cycle with scan_en=0 and scan_in=0.
REQ-018 UNLOAD SHALL last exactly CHAIN_LEN cycles with scan_en=1 and scan_in=0; at each edge in UNLOAD, captured <= {captured[CHAIN_LEN-2:0], chain_so}.
REQ-019 COMPARE SHALL last 1 cycle: done=1, pass=(captured==latched expect), scan_en=0; next state IDLE.
REQ-020 Test latency start-edge to done-high SHALL be 2*CHAIN_LEN+2 cycles (10 for CHAIN_LEN=4).
REQ-021 start while busy=1 SHALL be ignored with no effect on state, latched values or outputs.
REQ-022 start in the same cycle as done SHALL be ignored; a new test needs start in IDLE.
REQ-023 Shift index counter SHALL be ceil(log2(CHAIN_LEN))+1 bits, reset to 0 on each LOAD/UNLOAD entry, never wrap mid-phase.
REQ-024 scan_en SHALL be 0 in IDLE, CAPTURE, COMPARE.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, scan_en=0, scan_in=0, busy=0, done=0, pass=0, captured=0, index=0, latched pattern/expect=0, independent of clk.
REQ-026 Reset asserted mid-test (any state) SHALL abort the test with no done pulse; first start after rst deasserts SHALL run a full test.

Configuration
REQ-027 Macro SCAN_FAIL_CNT_EN: when defined, an extra output fail_cnt (8 bits) SHALL increment by 1 in each COMPARE cycle with pass=0, saturate at 255, reset to 0 only by rst.
REQ-028 Without SCAN_FAIL_CNT_EN, fail_cnt and its logic SHALL be absent; all other behaviour identical.

Verification (CHAIN_LEN=4, bench connects a 4-bit scan counter that increments in capture)
REQ-029 pattern 4'b0101, expect 4'b0110, start -> scan_in sequence 0,1,0,1 in LOAD; done 10 cycles after start; captured=4'b0110, pass=1.
REQ-030 pattern 4'b1111, expect 4'b0000 -> wrap-around; captured=4'b0000, pass=1.
REQ-031 pattern 4'b0011, expect 4'b0111 -> captured=4'b0100, pass=0; with SCAN_FAIL_CNT_EN, fail_cnt 0->1.
REQ-032 start pulsed again during LOAD and on the done cycle -> ignored; exactly one done pulse, busy low one cycle after done.
REQ-033 rst=0 during UNLOAD cycle 2 -> same-cycle scan_en=0, busy=0, captured=0, no done; following test with pattern 4'b1000 -> captured=4'b1001, pass=1 against expect 4'b1001.
REQ-034 With SCAN_FAIL_CNT_EN, 257 consecutive failing tests -> fail_cnt=255 (saturated).

Source files
------------

// File: rtl/scan_test_ctrl_if.sv
// Control-side bundle of scan_test_ctrl: the test request, the reference
// data, and the status/result returned to the requester.
interface scan_test_ctrl_if #(
  parameter int CHAIN_LEN = 4
);
  logic                 start;
  logic [CHAIN_LEN-1:0] pattern_in;
  logic [CHAIN_LEN-1:0] expect_in;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic [CHAIN_LEN-1:0] captured;

  modport master (
    output start, pattern_in, expect_in,
    input  busy, done, pass, captured
  );

  modport slave (
    input  start, pattern_in, expect_in,
    output busy, done, pass, captured
  );
endinterface

// File: rtl/scan_test_ctrl.sv
// Scan-test sequencer: shifts a pattern into a chain, pulses capture, unloads
// the chain and compares it. Optional saturating fail counter: SCAN_FAIL_CNT_EN.
module scan_test_ctrl #(
  parameter int CHAIN_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  scan_test_ctrl_if.slave   ctrl,
  output logic              scan_en,
  output logic              scan_in,
  input  logic              chain_so
`ifdef SCAN_FAIL_CNT_EN
  ,
  output logic [7:0]        fail_cnt
`endif
);

  localparam int IDX_W = $clog2(CHAIN_LEN) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    COMPARE
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [CHAIN_LEN-1:0] pat_q, pat_d;
  logic [CHAIN_LEN-1:0] exp_q, exp_d;
  logic [CHAIN_LEN-1:0] cap_q, cap_d;
  logic                 pass_q, pass_d;
  logic                 scan_en_q, scan_en_d;
  logic                 scan_in_q, scan_in_d;
  logic [CHAIN_LEN-1:0] load_sh;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    pat_d     = pat_q;
    exp_d     = exp_q;
    cap_d     = cap_q;
    pass_d    = pass_q;
    scan_en_d = 1'b0;
    scan_in_d = 1'b0;
    load_sh   = '0;

    // Outputs are registered, so each branch computes what the chain must see
    // during the cycle that follows this edge.
    unique case (state_q)
      IDLE: begin
        if (ctrl.start) begin
          pat_d     = ctrl.pattern_in;
          exp_d     = ctrl.expect_in;
          cap_d     = '0;
          pass_d    = 1'b0;
          idx_d     = '0;
          state_d   = LOAD;
          scan_en_d = 1'b1;
          scan_in_d = ctrl.pattern_in[CHAIN_LEN-1];
        end
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = CAPTURE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          load_sh   = pat_q << idx_d;
          scan_en_d = 1'b1;
          scan_in_d = load_sh[CHAIN_LEN-1];
        end
      end
      CAPTURE: begin
        idx_d     = '0;
        state_d   = UNLOAD;
        scan_en_d = 1'b1;
      end
      UNLOAD: begin
        cap_d = {cap_q[CHAIN_LEN-2:0], chain_so};
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          pass_d  = (cap_d == exp_q);
          state_d = COMPARE;
        end else begin
          idx_d     = idx_q + IDX_W'(1);
          scan_en_d = 1'b1;
        end
      end
      COMPARE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: the latched pattern/expect registers are reset along with the
    // control state so an aborted test leaves nothing stale behind.
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      pat_q     <= '0;
      exp_q     <= '0;
      cap_q     <= '0;
      pass_q    <= 1'b0;
      scan_en_q <= 1'b0;
      scan_in_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      idx_q     <= idx_d;
      pat_q     <= pat_d;
      exp_q     <= exp_d;
      cap_q     <= cap_d;
      pass_q    <= pass_d;
      scan_en_q <= scan_en_d;
      scan_in_q <= scan_in_d;
    end
  end

  assign scan_en       = scan_en_q;
  assign scan_in       = scan_in_q;
  assign ctrl.busy     = (state_q != IDLE);
  assign ctrl.done     = (state_q == COMPARE);
  assign ctrl.pass     = pass_q;
  assign ctrl.captured = cap_q;

`ifdef SCAN_FAIL_CNT_EN
  logic [7:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (state_q == COMPARE && !pass_q && fail_cnt_q != 8'hFF) begin
      fail_cnt_d = fail_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_cnt_q <= 8'd0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign fail_cnt = fail_cnt_q;
`endif

endmodule

// File: tb/tb_scan_test_ctrl.sv
// Bench for scan_test_ctrl (CHAIN_LEN=4) driving a 4-bit scan counter that
// increments whenever scan_en is low; outputs are compared to a test-level model.
module tb_scan_test_ctrl;

  localparam int N = 4;

  logic clk;
  logic rst;
  logic scan_en;
  logic scan_in;
  logic chain_so;
`ifdef SCAN_FAIL_CNT_EN
  logic [7:0] fail_cnt;
`endif

  scan_test_ctrl_if #(.CHAIN_LEN(N)) ctrl ();

  scan_test_ctrl #(.CHAIN_LEN(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .ctrl     (ctrl),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .chain_so (chain_so)
`ifdef SCAN_FAIL_CNT_EN
    ,
    .fail_cnt (fail_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Device under scan: FF0 takes scan_in, FF3 drives chain_so.
  logic [N-1:0] chain_ff = '0;
  always @(posedge clk) begin
    if (scan_en) chain_ff <= {chain_ff[N-2:0], scan_in};
    else         chain_ff <= chain_ff + 4'd1;
  end
  assign chain_so = chain_ff[N-1];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Test-level model: a test occupies 2N+2 cycles counted by m_o; the chain
  // returns pattern+1, so the result is known once the test is accepted.
  bit         m_act;
  int         m_o;
  logic [3:0] m_pat, m_exp, m_cap;
  logic       m_pass;
  logic [7:0] m_fcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_act = 0; m_o = 0; m_pat = 0; m_exp = 0; m_cap = 0; m_pass = 0; m_fcnt = 0;
    end else if (m_act) begin
      if (m_o == 2*N+1) begin
        m_act  = 0;
        m_cap  = m_pat + 4'd1;
        m_pass = (m_cap == m_exp);
        if (!m_pass && m_fcnt != 8'd255) m_fcnt = m_fcnt + 8'd1;
      end else begin
        m_o++;
      end
    end else if (ctrl.start) begin
      m_act = 1; m_o = 0;
      m_pat = ctrl.pattern_in; m_exp = ctrl.expect_in;
      m_cap = 0; m_pass = 0;
    end
  end

  logic [3:0] e_f, e_cap;
  logic       e_busy, e_done, e_en, e_in, e_pass;

  always @(negedge clk) begin
    e_f = m_pat + 4'd1;
    e_busy = 0; e_done = 0; e_en = 0; e_in = 0;
    e_cap = m_cap; e_pass = m_pass;
    if (!rst) begin
      e_cap = 0; e_pass = 0;
    end else if (m_act) begin
      e_busy = 1; e_cap = 0; e_pass = 0;
      if (m_o < N) begin
        e_en = 1; e_in = m_pat[N-1-m_o];
      end else if (m_o > N && m_o <= 2*N) begin
        e_en  = 1;
        e_cap = e_f >> (2*N+1 - m_o);
      end else if (m_o == 2*N+1) begin
        e_done = 1; e_cap = e_f; e_pass = (e_f == m_exp);
      end
    end
    check("busy",     ctrl.busy,     e_busy);
    check("done",     ctrl.done,     e_done);
    check("scan_en",  scan_en,       e_en);
    check("scan_in",  scan_in,       e_in);
    check("captured", ctrl.captured, e_cap);
    check("pass",     ctrl.pass,     e_pass);
`ifdef SCAN_FAIL_CNT_EN
    check("fail_cnt", fail_cnt,      m_fcnt);
`endif
  end

  // Starts a test one cycle after the call; lat counts edges from the cycle
  // start is presented to the cycle done is seen. poke re-asserts start in
  // LOAD and in the done cycle.
  task automatic run_test(input logic [3:0] pat, input logic [3:0] ev, input bit poke,
                          output int lat, output logic [3:0] seq,
                          output logic [3:0] cap, output logic ps);
    bit got;
    got = 0; lat = 0; seq = 0; cap = 0; ps = 0;
    @(posedge clk); #1;
    ctrl.pattern_in = pat; ctrl.expect_in = ev; ctrl.start = 1'b1;
    while (!got && lat < 40) begin
      @(posedge clk); lat++; #1;
      ctrl.start = poke && (lat == 2 || lat == 10);
      @(negedge clk);
      if (lat >= 1 && lat <= 4) seq[4-lat] = scan_in;
      if (ctrl.done) begin
        got = 1; cap = ctrl.captured; ps = ctrl.pass;
      end
    end
    if (!got) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ctrl.start = 1'b0;
  endtask

  int         lat, n_done;
  logic [3:0] seq, cap;
  logic       ps;

  initial begin
    rst = 1'b0;
    ctrl.start = 1'b0; ctrl.pattern_in = '0; ctrl.expect_in = '0;
    #22;
    check("rst_busy",     ctrl.busy,     0);
    check("rst_done",     ctrl.done,     0);
    check("rst_scan_en",  scan_en,       0);
    check("rst_captured", ctrl.captured, 0);
    check("rst_pass",     ctrl.pass,     0);
    rst = 1'b1;

    run_test(4'b0101, 4'b0110, 0, lat, seq, cap, ps);
    check("t1_latency", lat, 10);
    check("t1_scan_seq", seq, 4'b0101);
    check("t1_captured", cap, 4'b0110);
    check("t1_pass", ps, 1);

    run_test(4'b1111, 4'b0000, 0, lat, seq, cap, ps);
    check("t2_captured", cap, 4'b0000);
    check("t2_pass", ps, 1);

    run_test(4'b0011, 4'b0111, 0, lat, seq, cap, ps);
    check("t3_captured", cap, 4'b0100);
    check("t3_pass", ps, 0);
`ifdef SCAN_FAIL_CNT_EN
    check("t3_fail_cnt", fail_cnt, 1);
`endif

    run_test(4'b1010, 4'b1011, 1, lat, seq, cap, ps);
    check("t4_latency", lat, 10);
    check("t4_captured", cap, 4'b1011);
    @(negedge clk);
    check("t4_busy_after_done", ctrl.busy, 0);
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (ctrl.done) n_done++;
    end
    check("t4_extra_done", n_done, 0);

    // Abort during the third UNLOAD cycle with an asynchronous reset.
    @(posedge clk); #1;
    ctrl.pattern_in = 4'b0110; ctrl.expect_in = 4'b0111; ctrl.start = 1'b1;
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    repeat (N + 3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_scan_en",  scan_en,       0);
    check("abort_busy",     ctrl.busy,     0);
    check("abort_captured", ctrl.captured, 0);
    check("abort_done",     ctrl.done,     0);
    @(posedge clk); #3;
    rst = 1'b1;
    n_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (ctrl.done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_test(4'b1000, 4'b1001, 0, lat, seq, cap, ps);
    check("t5_latency", lat, 10);
    check("t5_captured", cap, 4'b1001);
    check("t5_pass", ps, 1);

    // Random traffic: start, pattern and expect change freely every cycle.
    repeat (1500) begin
      @(posedge clk); #1;
      ctrl.start      = ($urandom_range(0, 3) == 0);
      ctrl.pattern_in = 4'($urandom);
      ctrl.expect_in  = ($urandom_range(0, 1) == 1) ? ctrl.pattern_in + 4'd1 : 4'($urandom);
    end
    @(posedge clk); #1;
    ctrl.start = 1'b0;
    repeat (2*N + 4) @(posedge clk);

    // Drive the failure counter past saturation.
    repeat (257) begin
      logic [3:0] p;
      p = 4'($urandom);
      run_test(p, p + 4'd2, 0, lat, seq, cap, ps);
    end
    check("sat_last_pass", ps, 0);
`ifdef SCAN_FAIL_CNT_EN
    @(negedge clk);
    check("sat_fail_cnt", fail_cnt, 255);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
